vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Receive-side VGA block: samples an incoming hsync/vsync/blank/RGB stream in the pixel clock domain.
//  Recovers active-pixel coordinates, measures line/frame timing, reports lock against the expected mode.
//  Sits downstream of the graphics pipeline (loopback self-check) or behind an external video source.
// PARAMETERS
//  H_TOTAL      800  expected clocks per line (hsync fall to hsync fall)
//  V_TOTAL      525  expected lines per frame (hsync falls between vsync falls)
//  H_ACTIVE     640  pixels per line for which pixel_valid may assert
//  V_ACTIVE     480  active lines per frame for which pixel_valid may assert
//  LOCK_FRAMES  2    consecutive good frames required to enter LOCKED (1..15)
// PORTS
//  clk          in   1   pixel clock, 25 MHz
//  rst          in   1   asynchronous reset, active-high
//  hsync        in   1   horizontal sync, active-low
//  vsync        in   1   vertical sync, active-low
//  blank        in   1   1 = visible pixel, 0 = blanking
//  in_r/g/b     in   8   pixel colour, each [7:0]
//  pixelx       out  10  active-pixel column of current output pixel
//  pixely       out  10  active-line row of current output pixel
//  pixel_valid  out  1   out_r/g/b/pixelx/pixely hold a valid in-window pixel
//  out_r/g/b    out  8   registered pixel colour, each [7:0]
//  h_meas       out  11  last measured line length in clocks
//  v_meas       out  10  last measured frame length in lines
//  locked       out  1   timing matches parameters for LOCK_FRAMES frames
//  frame_start  out  1   one-cycle pulse on every vsync falling edge
//  timing_err   out  1   one-cycle pulse when a mismatch is detected while locked
// BEHAVIOUR
//  - Reset (async): every output 0; FSM = SEARCH; input regs idle (hsync=1, vsync=1, blank=0), so no edge right after release.
//  - Stage 1 registers all inputs; edges detected vs previous stage-1 value: hfall, vfall, bfall (blank 1->0).
//  - Line clock counter hcnt (11b, saturates at 2047): hfall -> hcnt<=0, h_meas<=hcnt+1; else hcnt+1.
//  - Line counter lcnt (10b, saturating): vfall -> v_meas<=lcnt+hfall, lcnt<=0; else lcnt<=lcnt+hfall.
//    Simultaneous hfall+vfall: the line counts in the frame that is ending.
//  - Active column ax: reset to 0 on hfall; +1 per stage-1 cycle with blank=1 (saturating).
//  - Active row ay: reset to 0 on vfall; +1 on each bfall (end of an active run).
//  - Stage 2 (outputs): out_rgb<=in regs, pixelx<=ax, pixely<=ay.
//    pixel_valid<=locked & blank & ax<H_ACTIVE & ay<V_ACTIVE. Input->output latency is exactly 2 clk.
//  - frame_start: registered vfall, same stage as outputs.
//  - Line check on every hfall: (hcnt+1)==H_TOTAL. Frame check on every vfall: (lcnt+hfall)==V_TOTAL.
//  - FSM (good-frame counter gcnt, 4b):
//    SEARCH: on vfall -> CHECK, gcnt<=0.
//    CHECK:  a failed line check sets a frame-bad flag. On vfall, frame good (no bad flag and frame check passes)
//            -> gcnt+1; reaching LOCK_FRAMES -> LOCKED. Frame bad -> gcnt<=0, stay CHECK. Bad flag clears on vfall.
//    LOCKED: locked=1; any failed line or frame check -> timing_err pulse, locked<=0, state SEARCH.
//  - pixel_valid drops on the same cycle locked drops.
//  - Mid-frame reset: all state cleared; lock needs 1 vfall plus LOCK_FRAMES good frames again.
//  - Counters never wrap; saturation guarantees mismatch, never a false match.
// TESTING
//  1. Nominal 640x480 stream, 3 frames -> locked rises at 2nd good frame's vfall (+1 clk), h_meas=800, v_meas=525.
//  2. Locked, pixel (x=0,y=0) colour 0xAA/0x55/0x0F -> 2 clk later pixel_valid=1, pixelx=0, pixely=0, out_r=0xAA.
//  3. Locked, one line stretched to 801 clocks -> timing_err pulse at that hfall, locked=0, h_meas=801.
//  4. Frame with 524 lines during CHECK -> gcnt cleared, locked only after 2 further good frames.
//  5. hsync/vsync held high (no source) -> locked=0, frame_start never pulses, hcnt saturates, no X on outputs.
//  6. rst asserted mid-line while locked -> all outputs 0 immediately (async); relock after 1+2 frames.

Source files
------------

// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
//   Receive-side VGA capture block in the pixel clock domain. Registers the
//   incoming hsync/vsync/blank/RGB stream, recovers active-pixel coordinates,
//   measures line and frame lengths, and reports lock against the expected
//   video mode.
//
// Ports
//   clk_i          pixel clock
//   rst_i          asynchronous reset, active-high
//   hsync_i        horizontal sync, active-low
//   vsync_i        vertical sync, active-low
//   blank_i        1 = visible pixel, 0 = blanking
//   in_r/g/b_i     pixel colour
//   pixelx_o       active column of the current output pixel
//   pixely_o       active row of the current output pixel
//   pixel_valid_o  output pixel is inside the active window while locked
//   out_r/g/b_o    registered pixel colour (2 clk after input)
//   h_meas_o       last measured line length in clocks
//   v_meas_o       last measured frame length in lines
//   locked_o       timing has matched the mode for LOCK_FRAMES frames
//   frame_start_o  one-cycle pulse per vsync falling edge
//   timing_err_o   one-cycle pulse on a timing mismatch while locked
// -----------------------------------------------------------------------------
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        blank_i,
    input  logic [7:0]  in_r_i,
    input  logic [7:0]  in_g_i,
    input  logic [7:0]  in_b_i,
    output logic [9:0]  pixelx_o,
    output logic [9:0]  pixely_o,
    output logic        pixel_valid_o,
    output logic [7:0]  out_r_o,
    output logic [7:0]  out_g_o,
    output logic [7:0]  out_b_o,
    output logic [10:0] h_meas_o,
    output logic [9:0]  v_meas_o,
    output logic        locked_o,
    output logic        frame_start_o,
    output logic        timing_err_o
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Stage 1: input registers and their previous values for edge detection
    logic       hs_q, vs_q, bl_q;
    logic       hs_prev_q, vs_prev_q, bl_prev_q;
    logic [7:0] r_q, g_q, b_q;

    // Timing counters
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic [9:0]  ax_q, ax_d;
    logic [9:0]  ay_q, ay_d;
    logic [10:0] h_meas_q, h_meas_d;
    logic [9:0]  v_meas_q, v_meas_d;

    // Lock FSM
    state_t      state_q, state_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic        bad_q, bad_d;
    logic        err_s;

    // Stage 2: output registers
    logic [9:0]  pixelx_q, pixely_q;
    logic        pixel_valid_q, locked_q, frame_start_q, timing_err_q;
    logic [7:0]  out_r_q, out_g_q, out_b_q;

    logic        hfall_s, vfall_s, bfall_s;
    logic [11:0] line_len_s;
    logic [10:0] frame_len_s;
    logic        line_ok_s, frame_ok_s, line_bad_s, frame_good_s;
    logic [3:0]  gcnt_inc_s;
    logic        locked_next_s, in_window_s;

    assign hfall_s = hs_prev_q & ~hs_q;
    assign vfall_s = vs_prev_q & ~vs_q;
    assign bfall_s = bl_prev_q & ~bl_q;

    // Widened sums so a saturated counter can never alias onto the expected mode
    assign line_len_s  = {1'b0, hcnt_q} + 12'd1;
    assign frame_len_s = {1'b0, lcnt_q} + {10'd0, hfall_s};
    assign line_ok_s   = (line_len_s == 12'(H_TOTAL));
    assign frame_ok_s  = (frame_len_s == 11'(V_TOTAL));
    assign line_bad_s  = hfall_s & ~line_ok_s;
    // A line ending together with vsync belongs to the frame being closed
    assign frame_good_s = ~bad_q & ~line_bad_s & frame_ok_s;
    assign gcnt_inc_s   = gcnt_q + 4'd1;

    assign locked_next_s = (state_d == ST_LOCKED);
    assign in_window_s   = (ax_q < 10'(H_ACTIVE)) & (ay_q < 10'(V_ACTIVE));

    // Counter next-state: line clocks, lines, active column and row
    always_comb begin
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        h_meas_d = h_meas_q;
        v_meas_d = v_meas_q;
        if (hfall_s) begin
            hcnt_d   = 11'd0;
            h_meas_d = line_len_s[11] ? 11'h7FF : line_len_s[10:0];
        end else if (hcnt_q != 11'h7FF) begin
            hcnt_d = hcnt_q + 11'd1;
        end else begin
            hcnt_d = hcnt_q;
        end
        if (vfall_s) begin
            lcnt_d   = 10'd0;
            v_meas_d = frame_len_s[10] ? 10'h3FF : frame_len_s[9:0];
        end else begin
            lcnt_d = frame_len_s[10] ? 10'h3FF : frame_len_s[9:0];
        end
        if (hfall_s) begin
            ax_d = 10'd0;
        end else if (bl_q && (ax_q != 10'h3FF)) begin
            ax_d = ax_q + 10'd1;
        end else begin
            ax_d = ax_q;
        end
        if (vfall_s) begin
            ay_d = 10'd0;
        end else if (bfall_s && (ay_q != 10'h3FF)) begin
            ay_d = ay_q + 10'd1;
        end else begin
            ay_d = ay_q;
        end
    end

    // Lock FSM next-state: search for vsync, count good frames, watch for errors
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        bad_d   = bad_q;
        err_s   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vfall_s) begin
                    state_d = ST_CHECK;
                    gcnt_d  = 4'd0;
                    bad_d   = 1'b0;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_CHECK: begin
                if (vfall_s) begin
                    bad_d = 1'b0;
                    if (frame_good_s) begin
                        gcnt_d = gcnt_inc_s;
                        if (gcnt_inc_s == 4'(LOCK_FRAMES)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        gcnt_d = 4'd0;
                    end
                end else if (line_bad_s) begin
                    bad_d = 1'b1;
                end else begin
                    bad_d = bad_q;
                end
            end
            ST_LOCKED: begin
                if (line_bad_s || (vfall_s && !frame_ok_s)) begin
                    err_s   = 1'b1;
                    state_d = ST_SEARCH;
                    gcnt_d  = 4'd0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                gcnt_d  = 4'd0;
                bad_d   = 1'b0;
            end
        endcase
    end

    // Stage 1 input capture; idle values keep release from producing an edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            bl_q      <= 1'b0;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            bl_prev_q <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
        end else begin
            hs_q      <= hsync_i;
            vs_q      <= vsync_i;
            bl_q      <= blank_i;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            bl_prev_q <= bl_q;
            r_q       <= in_r_i;
            g_q       <= in_g_i;
            b_q       <= in_b_i;
        end
    end

    // Counter and FSM state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q   <= 11'd0;
            lcnt_q   <= 10'd0;
            ax_q     <= 10'd0;
            ay_q     <= 10'd0;
            h_meas_q <= 11'd0;
            v_meas_q <= 10'd0;
            state_q  <= ST_SEARCH;
            gcnt_q   <= 4'd0;
            bad_q    <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            h_meas_q <= h_meas_d;
            v_meas_q <= v_meas_d;
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            bad_q    <= bad_d;
        end
    end

    // Stage 2 outputs; valid follows the next lock state so both drop together
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pixelx_q      <= 10'd0;
            pixely_q      <= 10'd0;
            pixel_valid_q <= 1'b0;
            out_r_q       <= 8'd0;
            out_g_q       <= 8'd0;
            out_b_q       <= 8'd0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            pixelx_q      <= ax_q;
            pixely_q      <= ay_q;
            pixel_valid_q <= locked_next_s & bl_q & in_window_s;
            out_r_q       <= r_q;
            out_g_q       <= g_q;
            out_b_q       <= b_q;
            locked_q      <= locked_next_s;
            frame_start_q <= vfall_s;
            timing_err_q  <= err_s;
        end
    end

    assign pixelx_o      = pixelx_q;
    assign pixely_o      = pixely_q;
    assign pixel_valid_o = pixel_valid_q;
    assign out_r_o       = out_r_q;
    assign out_g_o       = out_g_q;
    assign out_b_o       = out_b_q;
    assign h_meas_o      = h_meas_q;
    assign v_meas_o      = v_meas_q;
    assign locked_o      = locked_q;
    assign frame_start_o = frame_start_q;
    assign timing_err_o  = timing_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_capture
//   Self-checking bench for vga_capture using a reduced video mode
//   (20 clocks x 12 lines, 8x6 active window). Each frame drives hsync low for
//   the first 2 clocks of a line, vsync low for lines 0-1 (falling together
//   with hsync), and blank high for lines 3..9, clocks 4..12 -- one column and
//   one row beyond the active window so the window boundary is exercised.
// -----------------------------------------------------------------------------
module tb_vga_capture;

    localparam int H_T = 20;
    localparam int V_T = 12;
    localparam int H_A = 8;
    localparam int V_A = 6;
    localparam int NV  = 8;

    logic        clk_i;
    logic        rst_i;
    logic        hsync_i, vsync_i, blank_i;
    logic [7:0]  in_r_i, in_g_i, in_b_i;
    logic [9:0]  pixelx_o, pixely_o;
    logic        pixel_valid_o;
    logic [7:0]  out_r_o, out_g_o, out_b_o;
    logic [10:0] h_meas_o;
    logic [9:0]  v_meas_o;
    logic        locked_o, frame_start_o, timing_err_o;

    vga_capture #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_ACTIVE(H_A), .V_ACTIVE(V_A), .LOCK_FRAMES(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i),
        .in_r_i(in_r_i), .in_g_i(in_g_i), .in_b_i(in_b_i),
        .pixelx_o(pixelx_o), .pixely_o(pixely_o), .pixel_valid_o(pixel_valid_o),
        .out_r_o(out_r_o), .out_g_o(out_g_o), .out_b_o(out_b_o),
        .h_meas_o(h_meas_o), .v_meas_o(v_meas_o),
        .locked_o(locked_o), .frame_start_o(frame_start_o), .timing_err_o(timing_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int         ln;
        int         cy;
        logic       v;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t tbl [NV];

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    logic lk_prev = 1'b0;
    int   p_fr = -1, p_ln = -1, p_cy = -1;
    int   rise_fr = -1, rise_ln = -1, rise_cy = -1;
    int   err_cnt = 0, err_fr = -1, err_ln = -1, err_cy = -1, err_hmeas = -1;
    logic err_locked = 1'b1;
    int   fs_cnt = 0;
    int   fs_base;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] col_r(input int ln, input int cy);
        logic [3:0] a;
        logic [3:0] c;
        a = ln[3:0];
        c = cy[3:0];
        if (ln == 3 && cy == 4) return 8'hAA;
        else return {a, c};
    endfunction

    function automatic logic [7:0] col_b(input int ln, input int cy, input logic [7:0] r);
        if (ln == 3 && cy == 4) return 8'h0F;
        else return r ^ 8'h5A;
    endfunction

    // One clock of stimulus; afterwards outputs belong to the previous step
    task automatic step(input int fr, input int ln, input int cy,
                        input logic hs, input logic vs, input logic bl,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        hsync_i = hs; vsync_i = vs; blank_i = bl;
        in_r_i = r; in_g_i = g; in_b_i = b;
        @(posedge clk_i);
        #1;
        if (locked_o && !lk_prev) begin
            rise_fr = p_fr; rise_ln = p_ln; rise_cy = p_cy;
        end
        if (timing_err_o) begin
            err_cnt++;
            err_fr = p_fr; err_ln = p_ln; err_cy = p_cy;
            err_hmeas = int'(h_meas_o);
            err_locked = locked_o;
        end
        if (frame_start_o) fs_cnt++;
        if (chk_en) begin
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].ln == p_ln && tbl[i].cy == p_cy) begin
                    chk($sformatf("vec%0d_valid", i), pixel_valid_o, tbl[i].v);
                    chk($sformatf("vec%0d_x", i), pixelx_o, tbl[i].x);
                    chk($sformatf("vec%0d_y", i), pixely_o, tbl[i].y);
                    chk($sformatf("vec%0d_r", i), out_r_o, tbl[i].r);
                    chk($sformatf("vec%0d_g", i), out_g_o, tbl[i].g);
                    chk($sformatf("vec%0d_b", i), out_b_o, tbl[i].b);
                end
            end
        end
        lk_prev = locked_o;
        p_fr = fr; p_ln = ln; p_cy = cy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(-1, -1, -1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // Drive a frame; long_ln gets one extra clock, max_steps < 0 means whole frame
    task automatic drive_frame(input int fr, input int nlines, input int long_ln, input int max_steps);
        int n;
        int len;
        logic [7:0] r;
        n = 0;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == long_ln) ? H_T + 1 : H_T;
            for (int cy = 0; cy < len; cy++) begin
                if (max_steps < 0 || n < max_steps) begin
                    r = col_r(ln, cy);
                    step(fr, ln, cy, (cy >= 2), (ln >= 2),
                         (ln >= 3 && ln <= 9 && cy >= 4 && cy <= 12),
                         r, ~r, col_b(ln, cy, r));
                    n++;
                end
            end
        end
    endtask

    initial begin
        //              ln cy  v     x      y      r      g      b
        tbl[0] = '{3,  4, 1'b1, 10'd0, 10'd0, 8'hAA, 8'h55, 8'h0F};
        tbl[1] = '{3, 11, 1'b1, 10'd7, 10'd0, 8'h3B, 8'hC4, 8'h61};
        tbl[2] = '{3, 12, 1'b0, 10'd8, 10'd0, 8'h3C, 8'hC3, 8'h66};
        tbl[3] = '{3, 13, 1'b0, 10'd9, 10'd0, 8'h3D, 8'hC2, 8'h67};
        tbl[4] = '{5,  6, 1'b1, 10'd2, 10'd2, 8'h56, 8'hA9, 8'h0C};
        tbl[5] = '{8, 11, 1'b1, 10'd7, 10'd5, 8'h8B, 8'h74, 8'hD1};
        tbl[6] = '{9,  4, 1'b0, 10'd0, 10'd6, 8'h94, 8'h6B, 8'hCE};
        tbl[7] = '{10, 4, 1'b0, 10'd0, 10'd7, 8'hA4, 8'h5B, 8'hFE};

        rst_i = 1'b1;
        hsync_i = 1'b1; vsync_i = 1'b1; blank_i = 1'b0;
        in_r_i = 8'd0; in_g_i = 8'd0; in_b_i = 8'd0;
        #12;
        chk("rst_locked", locked_o, 0);
        chk("rst_valid", pixel_valid_o, 0);
        chk("rst_hmeas", h_meas_o, 0);
        chk("rst_vmeas", v_meas_o, 0);
        chk("rst_fs", frame_start_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(4);
        chk("release_no_fs", fs_cnt, 0);

        // Nominal lock: SEARCH->CHECK at frame 0, good frames 0 and 1, lock at frame 2 vfall
        drive_frame(0, V_T, -1, -1);
        drive_frame(1, V_T, -1, -1);
        chk("prelock_locked", locked_o, 0);
        chk("prelock_rise", rise_fr, -1);
        chk_en = 1'b1;
        drive_frame(2, V_T, -1, -1);
        chk_en = 1'b0;
        chk("lock_rise_fr", rise_fr, 2);
        chk("lock_rise_ln", rise_ln, 0);
        chk("lock_rise_cy", rise_cy, 0);
        chk("lock_locked", locked_o, 1);
        chk("lock_hmeas", h_meas_o, H_T);
        chk("lock_vmeas", v_meas_o, V_T);
        chk("lock_fs_cnt", fs_cnt, 3);
        chk("lock_no_err", err_cnt, 0);

        // Stretched line while locked: error pulse at the following hfall
        drive_frame(3, V_T, 5, -1);
        chk("long_err_cnt", err_cnt, 1);
        chk("long_err_fr", err_fr, 3);
        chk("long_err_ln", err_ln, 6);
        chk("long_err_cy", err_cy, 0);
        chk("long_err_hmeas", err_hmeas, H_T + 1);
        chk("long_err_locked", err_locked, 0);
        chk("long_unlocked", locked_o, 0);

        // Short frame during CHECK clears the good-frame count
        rise_fr = -1;
        drive_frame(4, V_T, -1, -1);
        drive_frame(5, V_T - 1, -1, -1);
        drive_frame(6, V_T, -1, -1);
        chk("short_vmeas", v_meas_o, V_T - 1);
        drive_frame(7, V_T, -1, -1);
        chk("short_not_locked", locked_o, 0);
        chk("short_no_rise", rise_fr, -1);
        drive_frame(8, V_T, -1, -1);
        chk("short_rise_fr", rise_fr, 8);
        chk("short_err_cnt", err_cnt, 1);

        // Asynchronous reset mid-line while locked, then relock
        drive_frame(9, V_T, -1, 5 * H_T + 8);
        chk("midrst_pre_locked", locked_o, 1);
        chk("midrst_pre_valid", pixel_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_locked", locked_o, 0);
        chk("midrst_valid", pixel_valid_o, 0);
        chk("midrst_outs", {pixelx_o, pixely_o, out_r_o, out_g_o, out_b_o, h_meas_o,
                            v_meas_o, frame_start_o, timing_err_o}, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rise_fr = -1;
        drive_frame(10, V_T, -1, -1);
        drive_frame(11, V_T, -1, -1);
        chk("relock_pending", locked_o, 0);
        drive_frame(12, V_T, -1, -1);
        chk("relock_rise_fr", rise_fr, 12);
        chk("relock_locked", locked_o, 1);

        // No source: syncs held high, counter saturates
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        fs_base = fs_cnt;
        idle(2100);
        chk("nosrc_locked", locked_o, 0);
        chk("nosrc_fs", fs_cnt - fs_base, 0);
        chk("nosrc_hmeas", h_meas_o, 0);
        chk("nosrc_valid", pixel_valid_o, 0);
        chk("nosrc_no_x", $isunknown({pixelx_o, pixely_o, pixel_valid_o, out_r_o, out_g_o,
                                       out_b_o, h_meas_o, v_meas_o, locked_o,
                                       frame_start_o, timing_err_o}), 0);
        step(-1, -1, -1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        step(-1, -1, -1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("nosrc_hmeas_sat", h_meas_o, 2047);
        chk("nosrc_no_err", err_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
